dm_byte_responder: RTL and testbench

- Data-memory responder at the memory end of the CPU's store/load byte-lane interface.
- Accepts one request at a time: a lane-aligned write word plus a 4-bit byte enable, or a read (byte enable all zero).
- Commits only the enabled byte lanes into word storage and returns the raw 32-bit word after a fixed, parameterised latency.
- The CPU-side extension unit performs lane selection and sign/zero extension on the returned word.

---
 rtl/dm_byte_responder.sv | 122 ++++++++++++
 tb/tb_dm_byte_responder.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/dm_byte_responder.sv
// Data-memory responder: byte-lane write merge, full-word read capture,
// fixed-latency response with valid/ready back-pressure.
module dm_byte_responder #(
    parameter int unsigned DEPTH_LOG2 = 12,
    parameter int unsigned LATENCY    = 2,
    parameter logic [31:0] BASE_ADDR  = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [31:0] req_addr,
    input  logic [3:0]  req_byteen,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [31:0] resp_rdata,
    output logic        resp_err
);

    localparam int unsigned DEPTH    = 1 << DEPTH_LOG2;
    localparam logic [1:0]  S_IDLE   = 2'd0;
    localparam logic [1:0]  S_WAIT   = 2'd1;
    localparam logic [1:0]  S_RESP   = 2'd2;
    localparam logic [3:0]  CNT_INIT = 4'(LATENCY - 1);

    logic [1:0]  state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        valid_q, valid_d;
    logic [31:0] rdata_q, rdata_d;
    logic        err_q, err_d;

    logic [31:0] mem_q [DEPTH];

    logic [31:0]           off;
    logic                  in_range;
    logic [DEPTH_LOG2-1:0] idx;
    logic                  accept;
    logic                  is_wr;

    // Offset above the storage window wraps or overflows the high bits.
    assign off      = req_addr - BASE_ADDR;
    assign in_range = (req_addr >= BASE_ADDR)
                   && ((off >> (DEPTH_LOG2 + 2)) == 32'd0);
    assign idx      = off[DEPTH_LOG2+1:2];
    assign accept   = req_valid && req_ready;
    assign is_wr    = (req_byteen != 4'b0000);

    assign req_ready  = (state_q == S_IDLE);
    assign resp_valid = valid_q;
    assign resp_rdata = rdata_q;
    assign resp_err   = err_q;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        valid_d = valid_q;
        rdata_d = rdata_q;
        err_d   = err_q;
        unique case (state_q)
            S_IDLE: begin
                if (accept) begin
                    rdata_d = (!in_range || is_wr) ? 32'd0 : mem_q[idx];
                    err_d   = !in_range;
                    if (LATENCY == 1) begin
                        state_d = S_RESP;
                        valid_d = 1'b1;
                    end else begin
                        state_d = S_WAIT;
                        cnt_d   = CNT_INIT;
                    end
                end
            end
            S_WAIT: begin
                if (cnt_q == 4'd1) begin
                    state_d = S_RESP;
                    valid_d = 1'b1;
                    cnt_d   = 4'd0;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            S_RESP: begin
                if (resp_ready) begin
                    state_d = S_IDLE;
                    valid_d = 1'b0;
                    rdata_d = 32'd0;
                    err_d   = 1'b0;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
            cnt_q   <= 4'd0;
            valid_q <= 1'b0;
            rdata_q <= 32'd0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            valid_q <= valid_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
        end
    end

    // Storage survives reset; only accepted in-range writes touch it.
    always_ff @(posedge clk) begin
        if (reset && accept && is_wr && in_range) begin
            for (int i = 0; i < 4; i++) begin
                if (req_byteen[i]) begin
                    mem_q[idx][8*i +: 8] <= req_wdata[8*i +: 8];
                end
            end
        end
    end

endmodule

// File: tb/tb_dm_byte_responder.sv
// Directed bench for dm_byte_responder: two instances (latency 2 and 4)
// driven through one handshake task.
module tb_dm_byte_responder;

    logic        clk = 1'b0;
    logic        reset;
    logic [1:0]  req_valid;
    logic [1:0]  req_ready;
    logic [1:0]  resp_valid;
    logic [1:0]  resp_ready;
    logic [1:0]  resp_err;
    logic [31:0] req_addr   [2];
    logic [31:0] req_wdata  [2];
    logic [31:0] resp_rdata [2];
    logic [3:0]  req_byteen [2];

    int n_chk  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    dm_byte_responder #(.DEPTH_LOG2(12), .LATENCY(2)) u_dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid[0]), .req_ready(req_ready[0]),
        .req_addr(req_addr[0]), .req_byteen(req_byteen[0]),
        .req_wdata(req_wdata[0]),
        .resp_valid(resp_valid[0]), .resp_ready(resp_ready[0]),
        .resp_rdata(resp_rdata[0]), .resp_err(resp_err[0])
    );

    dm_byte_responder #(.DEPTH_LOG2(12), .LATENCY(4)) u_dut4 (
        .clk(clk), .reset(reset),
        .req_valid(req_valid[1]), .req_ready(req_ready[1]),
        .req_addr(req_addr[1]), .req_byteen(req_byteen[1]),
        .req_wdata(req_wdata[1]),
        .resp_valid(resp_valid[1]), .resp_ready(resp_ready[1]),
        .resp_rdata(resp_rdata[1]), .resp_err(resp_err[1])
    );

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // One request/response; stall = cycles resp_ready stays low after
    // resp_valid rises, keep = hold req_valid high until the handshake.
    task automatic txn(input int s, input logic [31:0] a,
                       input logic [3:0] be, input logic [31:0] wd,
                       input int stall, input bit keep,
                       output logic [31:0] rd, output logic er,
                       output int lat);
        int n;
        bit bad;
        logic [31:0] hold;
        bad = 1'b0;
        req_addr[s]   = a;
        req_byteen[s] = be;
        req_wdata[s]  = wd;
        req_valid[s]  = 1'b1;
        n = 0;
        while (!req_ready[s] && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        if (!req_ready[s]) chk("ready_timeout", 32'd0, 32'd1);
        @(posedge clk); #1;
        if (!keep) req_valid[s] = 1'b0;
        lat = 1;
        while (!resp_valid[s] && lat < 40) begin
            if (req_ready[s]) bad = 1'b1;
            @(posedge clk); #1;
            lat++;
        end
        rd   = resp_rdata[s];
        er   = resp_err[s];
        hold = rd;
        for (int i = 0; i < stall; i++) begin
            @(posedge clk); #1;
            if (resp_rdata[s] !== hold || !resp_valid[s] || req_ready[s])
                bad = 1'b1;
        end
        if (req_ready[s]) bad = 1'b1;
        resp_ready[s] = 1'b1;
        @(posedge clk); #1;
        resp_ready[s] = 1'b0;
        req_valid[s]  = 1'b0;
        chk("hold_busy", 32'(bad), 32'd0);
        chk("resp_drop", 32'(resp_valid[s]), 32'd0);
        chk("ready_back", 32'(req_ready[s]), 32'd1);
    endtask

    initial begin
        logic [31:0] rd;
        logic        er;
        int          lat;
        bit          bad;

        reset      = 1'b0;
        req_valid  = '0;
        resp_ready = '0;
        for (int i = 0; i < 2; i++) begin
            req_addr[i]   = '0;
            req_wdata[i]  = '0;
            req_byteen[i] = '0;
        end
        repeat (3) @(posedge clk);
        #1;
        chk("rst_valid", 32'(resp_valid[0]), 32'd0);
        chk("rst_rdata", resp_rdata[0], 32'd0);
        chk("rst_err", 32'(resp_err[0]), 32'd0);
        reset = 1'b1;
        @(posedge clk); #1;
        chk("rst_ready0", 32'(req_ready[0]), 32'd1);
        chk("rst_ready1", 32'(req_ready[1]), 32'd1);

        txn(0, 32'h10, 4'b1111, 32'hDEADBEEF, 0, 1'b0, rd, er, lat);
        chk("wr_err", 32'(er), 32'd0);
        chk("wr_rdata", rd, 32'd0);
        chk("wr_lat", 32'(lat), 32'd2);
        txn(0, 32'h10, 4'b0000, 32'h0, 0, 1'b0, rd, er, lat);
        chk("rd_full", rd, 32'hDEADBEEF);
        chk("rd_lat", 32'(lat), 32'd2);

        txn(0, 32'h10, 4'b0100, 32'h00AA0000, 0, 1'b0, rd, er, lat);
        txn(0, 32'h10, 4'b0011, 32'h00001234, 0, 1'b0, rd, er, lat);
        txn(0, 32'h10, 4'b0000, 32'h0, 0, 1'b0, rd, er, lat);
        chk("rd_merge", rd, 32'hDEAA1234);

        txn(1, 32'h20, 4'b1111, 32'hCAFEF00D, 0, 1'b0, rd, er, lat);
        chk("l4_wr_lat", 32'(lat), 32'd4);
        txn(1, 32'h20, 4'b0000, 32'h0, 5, 1'b0, rd, er, lat);
        chk("l4_rd_lat", 32'(lat), 32'd4);
        chk("l4_rd_data", rd, 32'hCAFEF00D);

        txn(0, 32'h0, 4'b1111, 32'h0, 0, 1'b0, rd, er, lat);
        txn(0, 32'h4000, 4'b1111, 32'h11111111, 0, 1'b0, rd, er, lat);
        chk("oor_err", 32'(er), 32'd1);
        chk("oor_rdata", rd, 32'd0);
        txn(0, 32'h0, 4'b0000, 32'h0, 0, 1'b0, rd, er, lat);
        chk("w0_data", rd, 32'h0);
        chk("w0_err", 32'(er), 32'd0);
        txn(0, 32'h3FFC, 4'b0000, 32'h0, 0, 1'b0, rd, er, lat);
        chk("top_err", 32'(er), 32'd0);
        txn(0, 32'hFFFF_FFF0, 4'b0000, 32'h0, 0, 1'b0, rd, er, lat);
        chk("hi_err", 32'(er), 32'd1);
        chk("hi_rdata", rd, 32'd0);

        req_addr[0]   = 32'h10;
        req_byteen[0] = 4'b0000;
        req_valid[0]  = 1'b1;
        @(posedge clk); #1;
        req_valid[0] = 1'b0;
        chk("wait_busy", 32'(req_ready[0]), 32'd0);
        reset = 1'b0;
        bad = 1'b0;
        repeat (3) begin
            @(posedge clk); #1;
            if (resp_valid[0]) bad = 1'b1;
        end
        chk("rst_mid_valid", 32'(bad), 32'd0);
        reset = 1'b1;
        @(posedge clk); #1;
        chk("rst_mid_ready", 32'(req_ready[0]), 32'd1);
        chk("rst_mid_resp", 32'(resp_valid[0]), 32'd0);
        txn(0, 32'h10, 4'b0000, 32'h0, 0, 1'b0, rd, er, lat);
        chk("rst_mid_data", rd, 32'hDEAA1234);

        txn(0, 32'h13, 4'b1000, 32'h7F000000, 3, 1'b1, rd, er, lat);
        chk("lane3_err", 32'(er), 32'd0);
        chk("lane3_rdata", rd, 32'd0);
        txn(0, 32'h10, 4'b0000, 32'h0, 0, 1'b0, rd, er, lat);
        chk("lane3_word", rd, 32'h7FAA1234);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
